lsu_mc: RTL and testbench

- Multi-cycle, parametrised load/store unit; successor to the single-cycle DPI-based LSU.
- Accepts one memory uop per handshake from the EXU and issues one word-aligned request on a valid/ready memory port.
- Waits for the response, then returns aligned, extended load data or store completion to WBU over a valid/ready output.
- Supports XLEN 32 or 64 with byte/half/word/dword sizes.

---
 rtl/lsu_mc.sv | 204 ++++++++++++++++++++
 tb/tb_lsu_mc.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mc.sv
// Multi-cycle load/store unit: 3 cycles accept->result at minimum, 1 cycle for rejected accesses; one uop in flight.
// Stalls on mem_req_ready_i and out_ready_i with outputs held; LSU_MISALIGN_CHK_EN enables alignment faults.
module lsu_mc #(
  parameter int XLEN  = 32,
  parameter int NBYTE = XLEN/8,
  parameter int OFFW  = $clog2(XLEN/8)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             in_we_i,
  input  logic [1:0]       in_size_i,
  input  logic             in_unsigned_i,
  input  logic [XLEN-1:0]  in_addr_i,
  input  logic [XLEN-1:0]  in_wdata_i,
  output logic             mem_req_valid_o,
  input  logic             mem_req_ready_i,
  output logic             mem_req_we_o,
  output logic [XLEN-1:0]  mem_req_addr_o,
  output logic [XLEN-1:0]  mem_req_wdata_o,
  output logic [NBYTE-1:0] mem_req_wstrb_o,
  input  logic             mem_resp_valid_i,
  input  logic [XLEN-1:0]  mem_resp_rdata_i,
  input  logic             mem_resp_err_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  out_rdata_o,
  output logic             out_err_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [OFFW-1:0]   off_q, off_d;
  logic              in_ready_q, in_ready_d;
  logic              req_valid_q, req_valid_d;
  logic              req_we_q, req_we_d;
  logic [XLEN-1:0]   req_addr_q, req_addr_d;
  logic [XLEN-1:0]   req_wdata_q, req_wdata_d;
  logic [NBYTE-1:0]  req_wstrb_q, req_wstrb_d;
  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   out_rdata_q, out_rdata_d;
  logic              out_err_q, out_err_d;

  logic [OFFW-1:0]   in_off;
  logic [7:0]        base_strb;
  logic              misaligned;
  logic [XLEN-1:0]   beat_sh, ld_top, ld_ext;
  logic signed [XLEN-1:0] ld_top_s;
  logic [6:0]        nbits, ext_sh;

  assign in_off = in_addr_i[OFFW-1:0];

  always_comb begin
    base_strb = 8'h00;
    case (in_size_i)
      2'd0:    base_strb = 8'h01;
      2'd1:    base_strb = 8'h03;
      2'd2:    base_strb = 8'h0F;
      default: base_strb = 8'hFF;
    endcase
  end

`ifdef LSU_MISALIGN_CHK_EN
  logic [OFFW-1:0] align_mask;
  always_comb begin
    align_mask = '0;
    case (in_size_i)
      2'd0:    align_mask = '0;
      2'd1:    align_mask = OFFW'(1);
      2'd2:    align_mask = OFFW'(3);
      default: align_mask = OFFW'(7);
    endcase
  end
  assign misaligned = ((XLEN == 32) && (in_size_i == 2'd3)) || ((in_off & align_mask) != '0);
`else
  assign misaligned = (XLEN == 32) && (in_size_i == 2'd3);
`endif

  // Extension: park the access at the top of the word, then shift back down logically or arithmetically.
  always_comb begin
    beat_sh  = mem_resp_rdata_i >> {off_q, 3'b000};
    nbits    = 7'd8 << size_q;
    ext_sh   = (nbits >= 7'(XLEN)) ? 7'd0 : 7'(XLEN) - nbits;
    ld_top   = beat_sh << ext_sh;
    ld_top_s = ld_top;
    if (uns_q) ld_ext = ld_top >> ext_sh;
    else       ld_ext = ld_top_s >>> ext_sh;
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    off_d       = off_q;
    in_ready_d  = in_ready_q;
    req_valid_d = req_valid_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_wstrb_d = req_wstrb_q;
    out_valid_d = out_valid_q;
    out_rdata_d = out_rdata_q;
    out_err_d   = out_err_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          we_d       = in_we_i;
          size_d     = in_size_i;
          uns_d      = in_unsigned_i;
          off_d      = in_off;
          in_ready_d = 1'b0;
          if (misaligned) begin
            state_d     = S_RESP;
            out_valid_d = 1'b1;
            out_err_d   = 1'b1;
            out_rdata_d = '0;
          end else begin
            state_d     = S_REQ;
            req_valid_d = 1'b1;
            req_we_d    = in_we_i;
            req_addr_d  = {in_addr_i[XLEN-1:OFFW], {OFFW{1'b0}}};
            req_wdata_d = in_wdata_i << {in_off, 3'b000};
            req_wstrb_d = NBYTE'(base_strb << in_off);
          end
        end
      end
      S_REQ: begin
        if (mem_req_ready_i) begin
          req_valid_d = 1'b0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_resp_valid_i) begin
          state_d     = S_RESP;
          out_valid_d = 1'b1;
          out_err_d   = mem_resp_err_i;
          out_rdata_d = (we_q || mem_resp_err_i) ? '0 : ld_ext;
        end
      end
      S_RESP: begin
        if (out_ready_i) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          out_err_d   = 1'b0;
          out_rdata_d = '0;
          in_ready_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      size_q      <= 2'd0;
      uns_q       <= 1'b0;
      off_q       <= '0;
      in_ready_q  <= 1'b1;
      req_valid_q <= 1'b0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wstrb_q <= '0;
      out_valid_q <= 1'b0;
      out_rdata_q <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      off_q       <= off_d;
      in_ready_q  <= in_ready_d;
      req_valid_q <= req_valid_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_wstrb_q <= req_wstrb_d;
      out_valid_q <= out_valid_d;
      out_rdata_q <= out_rdata_d;
      out_err_q   <= out_err_d;
    end
  end

  assign in_ready_o      = in_ready_q;
  assign mem_req_valid_o = req_valid_q;
  assign mem_req_we_o    = req_we_q;
  assign mem_req_addr_o  = req_addr_q;
  assign mem_req_wdata_o = req_wdata_q;
  assign mem_req_wstrb_o = req_wstrb_q;
  assign out_valid_o     = out_valid_q;
  assign out_rdata_o     = out_rdata_q;
  assign out_err_o       = out_err_q;

endmodule

// File: tb/tb_lsu_mc.sv
// Bench for lsu_mc: XLEN=32 and XLEN=64 instances against a byte-level reference model.
module tb_lsu_mc;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic ok, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    if (ok !== 1'b1) begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic        in_valid = 1'b0, in_we = 1'b0, in_uns = 1'b0;
  logic [1:0]  in_size = 2'd0;
  logic [63:0] in_addr = '0, in_wdata = '0, resp_rdata = '0;
  logic        req_ready = 1'b0, resp_valid = 1'b0, resp_err = 1'b0, out_ready = 1'b0;

  logic        a_in_ready, a_req_valid, a_req_we, a_out_valid, a_out_err;
  logic [31:0] a_req_addr, a_req_wdata, a_out_rdata;
  logic [3:0]  a_wstrb;
  logic        b_in_ready, b_req_valid, b_req_we, b_out_valid, b_out_err;
  logic [63:0] b_req_addr, b_req_wdata, b_out_rdata;
  logic [7:0]  b_wstrb;

  lsu_mc #(.XLEN(32)) u32 (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid & ~sel), .in_ready_o(a_in_ready), .in_we_i(in_we),
    .in_size_i(in_size), .in_unsigned_i(in_uns), .in_addr_i(in_addr[31:0]), .in_wdata_i(in_wdata[31:0]),
    .mem_req_valid_o(a_req_valid), .mem_req_ready_i(req_ready & ~sel), .mem_req_we_o(a_req_we),
    .mem_req_addr_o(a_req_addr), .mem_req_wdata_o(a_req_wdata), .mem_req_wstrb_o(a_wstrb),
    .mem_resp_valid_i(resp_valid & ~sel), .mem_resp_rdata_i(resp_rdata[31:0]), .mem_resp_err_i(resp_err),
    .out_valid_o(a_out_valid), .out_ready_i(out_ready & ~sel), .out_rdata_o(a_out_rdata), .out_err_o(a_out_err)
  );

  lsu_mc #(.XLEN(64)) u64 (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid & sel), .in_ready_o(b_in_ready), .in_we_i(in_we),
    .in_size_i(in_size), .in_unsigned_i(in_uns), .in_addr_i(in_addr), .in_wdata_i(in_wdata),
    .mem_req_valid_o(b_req_valid), .mem_req_ready_i(req_ready & sel), .mem_req_we_o(b_req_we),
    .mem_req_addr_o(b_req_addr), .mem_req_wdata_o(b_req_wdata), .mem_req_wstrb_o(b_wstrb),
    .mem_resp_valid_i(resp_valid & sel), .mem_resp_rdata_i(resp_rdata), .mem_resp_err_i(resp_err),
    .out_valid_o(b_out_valid), .out_ready_i(out_ready & sel), .out_rdata_o(b_out_rdata), .out_err_o(b_out_err)
  );

  logic        o_in_ready, o_req_valid, o_req_we, o_out_valid, o_out_err;
  logic [63:0] o_req_addr, o_req_wdata, o_out_rdata;
  logic [7:0]  o_wstrb;
  assign o_in_ready  = sel ? b_in_ready  : a_in_ready;
  assign o_req_valid = sel ? b_req_valid : a_req_valid;
  assign o_req_we    = sel ? b_req_we    : a_req_we;
  assign o_req_addr  = sel ? b_req_addr  : {32'b0, a_req_addr};
  assign o_req_wdata = sel ? b_req_wdata : {32'b0, a_req_wdata};
  assign o_wstrb     = sel ? b_wstrb     : {4'b0, a_wstrb};
  assign o_out_valid = sel ? b_out_valid : a_out_valid;
  assign o_out_rdata = sel ? b_out_rdata : {32'b0, a_out_rdata};
  assign o_out_err   = sel ? b_out_err   : a_out_err;

  // Reference model: byte-lane view of the access.
  function automatic int nb_of(input logic s);
    return s ? 8 : 4;
  endfunction

  function automatic logic mis_f(input logic s, input logic [1:0] sz, input logic [63:0] a);
    int off;
    off = int'(a % 64'(nb_of(s)));
    if (!s && sz == 2'd3) return 1'b1;
`ifdef LSU_MISALIGN_CHK_EN
    if ((off % (1 << sz)) != 0) return 1'b1;
`endif
    if (off < 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [7:0] strb_f(input logic s, input logic [1:0] sz, input logic [63:0] a);
    logic [7:0] r;
    int off;
    r = '0;
    off = int'(a % 64'(nb_of(s)));
    for (int i = 0; i < (1 << sz); i++)
      if (off + i < nb_of(s)) r[off+i] = 1'b1;
    return r;
  endfunction

  function automatic logic [63:0] wdat_f(input logic s, input logic [63:0] a, input logic [63:0] wd);
    logic [63:0] r;
    int off;
    r = '0;
    off = int'(a % 64'(nb_of(s)));
    for (int j = 0; j < nb_of(s); j++)
      if (j >= off) r[8*j +: 8] = wd[8*(j-off) +: 8];
    return r;
  endfunction

  function automatic logic [63:0] load_f(input logic s, input logic [1:0] sz, input logic uns,
                                         input logic [63:0] a, input logic [63:0] beat);
    logic [63:0] v;
    int off, bytes, xlen;
    v = '0;
    xlen = 8 * nb_of(s);
    off = int'(a % 64'(nb_of(s)));
    bytes = 1 << sz;
    for (int i = 0; i < bytes; i++)
      if (off + i < nb_of(s)) v[8*i +: 8] = beat[8*(off+i) +: 8];
    if (!uns && 8 * bytes < xlen && v[8*bytes-1])
      for (int k = 8 * bytes; k < xlen; k++) v[k] = 1'b1;
    return v;
  endfunction

  task automatic do_txn(input logic s, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [63:0] a_in, input logic [63:0] wd_in, input logic [63:0] beat_in,
                        input logic rerr, input int rstall, input int ostall,
                        output logic [63:0] got_rd, output logic got_err);
    logic [63:0] mask, a, wd, beat, exp_rd, exp_addr, exp_wd;
    logic [7:0]  exp_strb;
    logic        mis, exp_err;
    mask = s ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    a = a_in & mask; wd = wd_in & mask; beat = beat_in & mask;
    mis = mis_f(s, sz, a);
    exp_addr = a & ~64'(nb_of(s) - 1);
    exp_strb = strb_f(s, sz, a);
    exp_wd   = wdat_f(s, a, wd);
    @(negedge clk);
    sel = s; in_we = we; in_size = sz; in_uns = uns; in_addr = a; in_wdata = wd; in_valid = 1'b1;
    chk("in_ready_idle", (o_in_ready === 1'b1), o_in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    in_addr = {$urandom, $urandom};
    if (mis) begin
      chk("mis_no_req", (o_req_valid === 1'b0), o_req_valid, 1'b0);
    end else begin
      for (int i = 0; i <= rstall; i++) begin
        chk("req_valid", (o_req_valid === 1'b1), o_req_valid, 1'b1);
        chk("req_we", (o_req_we === we), o_req_we, we);
        chk("req_addr", (o_req_addr === exp_addr), o_req_addr, exp_addr);
        chk("req_wstrb", (o_wstrb === exp_strb), o_wstrb, exp_strb);
        chk("req_wdata", (o_req_wdata === exp_wd), o_req_wdata, exp_wd);
        chk("busy_in_ready", (o_in_ready === 1'b0), o_in_ready, 1'b0);
        chk("early_out_valid", (o_out_valid === 1'b0), o_out_valid, 1'b0);
        resp_valid = (i < rstall) ? 1'($urandom) : 1'b0;
        resp_rdata = {$urandom, $urandom};
        if (i == rstall) req_ready = 1'b1;
        @(negedge clk);
      end
      req_ready = 1'b0;
      chk("single_handshake", (o_req_valid === 1'b0), o_req_valid, 1'b0);
      chk("wait_out_valid", (o_out_valid === 1'b0), o_out_valid, 1'b0);
      resp_valid = 1'b1; resp_rdata = beat; resp_err = rerr;
      @(negedge clk);
      resp_valid = 1'b0; resp_err = 1'b0; resp_rdata = {$urandom, $urandom};
    end
    exp_err = mis | rerr;
    exp_rd  = (exp_err || we) ? 64'h0 : load_f(s, sz, uns, a, beat);
    got_rd = o_out_rdata; got_err = o_out_err;
    for (int i = 0; i <= ostall; i++) begin
      chk("out_valid", (o_out_valid === 1'b1), o_out_valid, 1'b1);
      chk("out_rdata", (o_out_rdata === exp_rd), o_out_rdata, exp_rd);
      chk("out_err", (o_out_err === exp_err), o_out_err, exp_err);
      chk("resp_in_ready", (o_in_ready === 1'b0), o_in_ready, 1'b0);
      if (i == ostall) out_ready = 1'b1;
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("out_drop", (o_out_valid === 1'b0), o_out_valid, 1'b0);
    chk("back_idle", (o_in_ready === 1'b1), o_in_ready, 1'b1);
  endtask

  logic [63:0] rd;
  logic        er;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_in_ready", (o_in_ready === 1'b1), o_in_ready, 1'b1);
    chk("rst_req_valid", (o_req_valid === 1'b0), o_req_valid, 1'b0);
    chk("rst_out_valid", (o_out_valid === 1'b0), o_out_valid, 1'b0);
    chk("rst_out_rdata", (o_out_rdata === 64'h0), o_out_rdata, 64'h0);
    chk("rst_wstrb", (o_wstrb === 8'h0), o_wstrb, 8'h0);
    rst_n = 1'b1;
    @(negedge clk);

    do_txn(1'b0, 1'b1, 2'd2, 1'b0, 64'h8000_0004, 64'hDEAD_BEEF, 64'h0, 1'b0, 0, 0, rd, er);
    chk("sw_err", (er === 1'b0), er, 1'b0);
    do_txn(1'b0, 1'b0, 2'd0, 1'b0, 64'h8000_0003, 64'h0, 64'h80FF_1234, 1'b0, 0, 0, rd, er);
    chk("lb_data", (rd === 64'hFFFF_FF80), rd, 64'hFFFF_FF80);
    do_txn(1'b0, 1'b0, 2'd0, 1'b1, 64'h8000_0003, 64'h0, 64'h80FF_1234, 1'b0, 0, 0, rd, er);
    chk("lbu_data", (rd === 64'h0000_0080), rd, 64'h0000_0080);
    do_txn(1'b0, 1'b0, 2'd1, 1'b0, 64'h8000_0002, 64'h0, 64'h80FF_1234, 1'b0, 0, 0, rd, er);
    chk("lh_data", (rd === 64'hFFFF_80FF), rd, 64'hFFFF_80FF);
    do_txn(1'b0, 1'b1, 2'd0, 1'b0, 64'h8000_0001, 64'hAB, 64'h0, 1'b0, 4, 0, rd, er);
    chk("sb_rdata", (rd === 64'h0), rd, 64'h0);
    do_txn(1'b0, 1'b1, 2'd2, 1'b0, 64'h8000_0002, 64'h1122_3344, 64'h0, 1'b0, 0, 0, rd, er);
    do_txn(1'b0, 1'b0, 2'd2, 1'b0, 64'h8000_0002, 64'h0, 64'h1234_5678, 1'b0, 0, 0, rd, er);
`ifdef LSU_MISALIGN_CHK_EN
    chk("lw_mis_err", (er === 1'b1), er, 1'b1);
`else
    chk("lw_mis_noerr", (er === 1'b0), er, 1'b0);
`endif
    do_txn(1'b0, 1'b0, 2'd3, 1'b0, 64'h8000_0000, 64'h0, 64'h0, 1'b0, 0, 0, rd, er);
    chk("d_on_32_err", (er === 1'b1), er, 1'b1);
    do_txn(1'b1, 1'b0, 2'd2, 1'b1, 64'h8000_0004, 64'h0, 64'h8765_4321_0000_0000, 1'b0, 0, 0, rd, er);
    chk("lwu64_data", (rd === 64'h0000_0000_8765_4321), rd, 64'h0000_0000_8765_4321);
    do_txn(1'b1, 1'b0, 2'd3, 1'b0, 64'h8000_0000, 64'h0, 64'h8765_4321_0000_0000, 1'b0, 0, 0, rd, er);
    chk("ld64_data", (rd === 64'h8765_4321_0000_0000), rd, 64'h8765_4321_0000_0000);
    do_txn(1'b1, 1'b0, 2'd3, 1'b0, 64'h8000_0008, 64'h0, 64'hFFFF_0000_1111_2222, 1'b1, 0, 0, rd, er);
    chk("bus_err", (er === 1'b1), er, 1'b1);
    chk("bus_err_rdata", (rd === 64'h0), rd, 64'h0);
    do_txn(1'b0, 1'b0, 2'd2, 1'b0, 64'h8000_0010, 64'h0, 64'hCAFE_F00D, 1'b0, 0, 3, rd, er);
    chk("held_data", (rd === 64'hCAFE_F00D), rd, 64'hCAFE_F00D);

    // Reset while waiting for the memory response.
    @(negedge clk);
    sel = 1'b0; in_we = 1'b0; in_size = 2'd2; in_addr = 64'h8000_0020; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    chk("pre_rst_wait", (o_req_valid === 1'b0), o_req_valid, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", (o_in_ready === 1'b1), o_in_ready, 1'b1);
    chk("mid_rst_req_valid", (o_req_valid === 1'b0), o_req_valid, 1'b0);
    chk("mid_rst_out_valid", (o_out_valid === 1'b0), o_out_valid, 1'b0);
    chk("mid_rst_req_addr", (o_req_addr === 64'h0), o_req_addr, 64'h0);
    @(negedge clk);
    rst_n = 1'b1; resp_valid = 1'b1; resp_rdata = 64'h1234_5678;
    @(negedge clk);
    resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("late_resp_ignored", (o_out_valid === 1'b0), o_out_valid, 1'b0);
      chk("late_resp_idle", (o_in_ready === 1'b1), o_in_ready, 1'b1);
      @(negedge clk);
    end

    for (int t = 0; t < 120; t++) begin
      logic s;
      s = 1'($urandom);
      do_txn(s, 1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
             {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
             ($urandom_range(0, 7) == 0), $urandom_range(0, 2), $urandom_range(0, 2), rd, er);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
